// File: rtl/cas_player.sv
// cas_player: plays a CAS tape image from SDRAM as the 1200-baud MSX FSK
// signal. A prefetcher fills the next 8-byte group while the current group is
// being played, so consecutive groups join without extra ticks.
module cas_player #(
  parameter int HALF_1    = 746,
  parameter int HALF_0    = 1492,
  parameter int LONG_HDR  = 16000,
  parameter int SHORT_HDR = 4000,
  parameter int GAP_TICKS = 1789773
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        ce_3m58_p,
  input  logic        cas_motor,
  input  logic        play_en,
  input  logic        rewind,
  input  logic [26:0] cas_size,
  output logic [26:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ack,
  output logic        cas_audio_out,
  output logic        playing,
  output logic        eof
);

  localparam logic [63:0] MARKER  = 64'h1FA6_DEBA_CC13_7D74;
  localparam logic [20:0] T_H1    = 21'(HALF_1 - 1);
  localparam logic [20:0] T_H0    = 21'(HALF_0 - 1);
  localparam logic [20:0] T_GAP   = 21'(GAP_TICKS - 1);
  localparam logic [15:0] C_LONG  = 16'(LONG_HDR - 1);
  localparam logic [15:0] C_SHORT = 16'(SHORT_HDR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_GAP, S_HDR, S_SEND, S_DONE
  } state_t;

  state_t      state;
  logic        lvl;
  logic [20:0] tc;
  logic [15:0] hc;
  logic [2:0]  bi;
  logic [3:0]  bt;
  logic [1:0]  hf;
  logic [7:0]  gbuf [8];
  logic [7:0]  gvalid;

  logic [26:0] fpos;
  logic [3:0]  fi;
  logic [7:0]  nbuf [8];
  logic [7:0]  nvalid;
  logic        nready;
  logic        nend;
  logic        discard;

  logic        run;
  logic        cur_bit;
  logic        next_bit;
  logic        bit_last;
  logic        grp_last;
  logic        take;
  logic        marker_hit;
  logic [27:0] fetch_addr;
  logic        past_end;

  assign run           = cas_motor & play_en & ~eof;
  assign cas_audio_out = lvl & run;
  assign fetch_addr    = {1'b0, fpos} + 28'(fi);
  assign past_end      = fetch_addr >= {1'b0, cas_size};

  // Bit being sent (start, 8 data LSB first, 2 stop), its last half and the group end.
  always_comb begin
    cur_bit = 1'b1;
    if (bt == 4'd0) cur_bit = 1'b0;
    else if (bt <= 4'd8) cur_bit = gbuf[bi][3'(bt - 4'd1)];
    next_bit = (bt < 4'd8) ? gbuf[bi][bt[2:0]] : 1'b1;
    bit_last = cur_bit ? (hf == 2'd3) : (hf == 2'd1);
    grp_last = ((state == S_HDR) && (hc == 16'd0) && hf[0]) ||
               ((state == S_SEND) && (bt == 4'd10) && bit_last &&
                ((bi == 3'd7) || !gvalid[bi + 3'd1]));
    take = run && nready &&
           ((state == S_FETCH) || (ce_3m58_p && (tc == 21'd0) && grp_last));
  end

  // A group is a block marker only when all eight bytes are present and match.
  always_comb begin
    marker_hit = &nvalid;
    for (int i = 0; i < 8; i++)
      if (nbuf[i] != MARKER[63 - 8*i -: 8]) marker_hit = 1'b0;
  end

  // Prefetcher: reads the next group byte by byte; a read cut by rewind is dropped.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      fpos     <= '0;
      fi       <= '0;
      nready   <= 1'b0;
      nend     <= 1'b0;
      discard  <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      nvalid   <= '0;
      for (int i = 0; i < 8; i++) nbuf[i] <= '0;
    end else if (rewind) begin
      fpos   <= '0;
      fi     <= '0;
      nready <= 1'b0;
      nend   <= 1'b0;
      if (mem_rd && !mem_ack) begin
        discard <= 1'b1;
      end else begin
        mem_rd   <= 1'b0;
        mem_addr <= '0;
        discard  <= 1'b0;
      end
    end else if (mem_rd) begin
      if (mem_ack) begin
        mem_rd <= 1'b0;
        if (discard) begin
          discard  <= 1'b0;
          mem_addr <= '0;
        end else begin
          nbuf[fi[2:0]]   <= mem_dout;
          nvalid[fi[2:0]] <= 1'b1;
          fi              <= fi + 4'd1;
        end
      end
    end else if (take) begin
      fpos   <= fpos + 27'd8;
      fi     <= '0;
      nready <= 1'b0;
      nend   <= 1'b0;
    end else if (run && !nready && !discard && (state != S_DONE)) begin
      if ((fi == 4'd0) && (fpos >= cas_size)) begin
        nready <= 1'b1;
        nend   <= 1'b1;
      end else if (fi == 4'd8) begin
        nready <= 1'b1;
      end else if (past_end) begin
        nvalid[fi[2:0]] <= 1'b0;
        fi              <= fi + 4'd1;
      end else begin
        mem_rd   <= 1'b1;
        mem_addr <= fetch_addr[26:0];
      end
    end
  end

  // Player FSM: walks header cycles and bit halves with a down-counting tick timer.
  //   state   | meaning
  //   S_IDLE  | waiting for run
  //   S_FETCH | waiting for the next group, output low
  //   S_GAP   | silence before a short header
  //   S_HDR   | 2400 Hz header cycles
  //   S_SEND  | serialising the valid bytes of a group
  //   S_DONE  | image exhausted, eof set
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      lvl     <= 1'b0;
      tc      <= '0;
      hc      <= '0;
      bi      <= '0;
      bt      <= '0;
      hf      <= '0;
      eof     <= 1'b0;
      playing <= 1'b0;
      gvalid  <= '0;
      for (int i = 0; i < 8; i++) gbuf[i] <= '0;
    end else begin
      playing <= run && (state != S_IDLE) && (state != S_DONE);
      if (rewind) begin
        state <= S_IDLE;
        eof   <= 1'b0;
        lvl   <= 1'b0;
        tc    <= '0;
        hc    <= '0;
        bi    <= '0;
        bt    <= '0;
        hf    <= '0;
      end else if (run) begin
        if (state == S_IDLE) begin
          state <= S_FETCH;
        end else if (take) begin
          gbuf   <= nbuf;
          gvalid <= nvalid;
          bi     <= '0;
          bt     <= '0;
          hf     <= '0;
          if (nend) begin
            state <= S_DONE;
            eof   <= 1'b1;
            lvl   <= 1'b0;
          end else if (marker_hit && (fpos == 27'd0)) begin
            state <= S_HDR;
            hc    <= C_LONG;
            lvl   <= 1'b1;
            tc    <= T_H1;
          end else if (marker_hit) begin
            state <= S_GAP;
            lvl   <= 1'b0;
            tc    <= T_GAP;
          end else begin
            state <= S_SEND;
            lvl   <= 1'b1;
            tc    <= T_H0;
          end
        end else if (ce_3m58_p &&
                     ((state == S_GAP) || (state == S_HDR) || (state == S_SEND))) begin
          if (tc != 21'd0) begin
            tc <= tc - 21'd1;
          end else begin
            case (state)
              S_GAP: begin
                state <= S_HDR;
                hc    <= C_SHORT;
                hf    <= '0;
                lvl   <= 1'b1;
                tc    <= T_H1;
              end
              S_HDR: begin
                if (!hf[0]) begin
                  hf  <= 2'd1;
                  lvl <= 1'b0;
                  tc  <= T_H1;
                end else if (hc != 16'd0) begin
                  hc  <= hc - 16'd1;
                  hf  <= '0;
                  lvl <= 1'b1;
                  tc  <= T_H1;
                end else begin
                  state <= S_FETCH;
                  lvl   <= 1'b0;
                end
              end
              S_SEND: begin
                if (!bit_last) begin
                  hf  <= hf + 2'd1;
                  lvl <= ~lvl;
                  tc  <= cur_bit ? T_H1 : T_H0;
                end else if (bt != 4'd10) begin
                  bt  <= bt + 4'd1;
                  hf  <= '0;
                  lvl <= 1'b1;
                  tc  <= next_bit ? T_H1 : T_H0;
                end else if (!grp_last) begin
                  bi  <= bi + 3'd1;
                  bt  <= '0;
                  hf  <= '0;
                  lvl <= 1'b1;
                  tc  <= T_H0;
                end else begin
                  state <= S_FETCH;
                  lvl   <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// tb_cas_player: scoreboard bench. Expected waveform segments (level, ticks)
// and read addresses are queued from the image; a monitor measures the DUT
// output in ce ticks and a memory model checks the read handshake.
module tb_cas_player;
  localparam int H1 = 3;
  localparam int H0 = 6;
  localparam int LH = 4;
  localparam int SH = 3;
  localparam int GT = 25;
  localparam logic [63:0] MK = 64'h1FA6_DEBA_CC13_7D74;

  logic        clk21m = 1'b0;
  logic        reset = 1'b1;
  logic        ce_3m58_p = 1'b0;
  logic        cas_motor = 1'b0;
  logic        play_en = 1'b0;
  logic        rewind = 1'b0;
  logic [26:0] cas_size = '0;
  logic [26:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        mem_ack;
  logic        cas_audio_out;
  logic        playing;
  logic        eof;

  typedef struct { bit lvl; int n; } seg_t;
  seg_t  exp_q[$];
  int    addr_q[$];
  logic [7:0] img [64];
  int    ack_lat = 1;
  int    n_checks = 0;
  int    n_fail = 0;
  bit    flush_req = 0;
  bit    mon_started = 0;
  bit    mon_cur = 0;
  int    mon_cnt = 0;
  int    mm_a;
  int    mm_lat;

  cas_player #(.HALF_1(H1), .HALF_0(H0), .LONG_HDR(LH), .SHORT_HDR(SH),
               .GAP_TICKS(GT)) dut (
    .clk21m(clk21m), .reset(reset), .ce_3m58_p(ce_3m58_p),
    .cas_motor(cas_motor), .play_en(play_en), .rewind(rewind),
    .cas_size(cas_size), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .cas_audio_out(cas_audio_out),
    .playing(playing), .eof(eof)
  );

  always #5 clk21m = ~clk21m;

  task automatic chk(input string tag, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
    end
  endtask

  task automatic push_seg(input bit lvl, input int n);
    if (lvl == 1'b0 && exp_q.size() > 0 && exp_q[$].lvl == 1'b0)
      exp_q[$].n = exp_q[$].n + n;
    else
      exp_q.push_back('{lvl, n});
  endtask

  task automatic push_bit(input bit b);
    if (b) begin
      push_seg(1, H1); push_seg(0, H1); push_seg(1, H1); push_seg(0, H1);
    end else begin
      push_seg(1, H0); push_seg(0, H0);
    end
  endtask

  task automatic push_byte(input logic [7:0] v);
    push_bit(1'b0);
    for (int i = 0; i < 8; i++) push_bit(v[i]);
    push_bit(1'b1);
    push_bit(1'b1);
  endtask

  task automatic push_hdr(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      push_seg(1, H1);
      push_seg(0, H1);
    end
  endtask

  task automatic build_expect(input int size);
    logic [63:0] m;
    bit hit;
    m = MK;
    exp_q.delete();
    addr_q.delete();
    for (int a = 0; a < size; a++) addr_q.push_back(a);
    for (int p = 0; p < size; p += 8) begin
      hit = (p + 8 <= size);
      if (hit)
        for (int i = 0; i < 8; i++)
          if (img[p+i] != m[63 - 8*i -: 8]) hit = 0;
      if (hit && p == 0) push_hdr(LH);
      else if (hit) begin
        push_seg(0, GT);
        push_hdr(SH);
      end else
        for (int i = p; i < size && i < p + 8; i++) push_byte(img[i]);
    end
  endtask

  task automatic put_marker(input int p);
    logic [63:0] m;
    m = MK;
    for (int i = 0; i < 8; i++) img[p+i] = m[63 - 8*i -: 8];
  endtask

  task automatic check_seg(input bit lvl, input int n);
    seg_t e;
    chk("seg_expected_avail", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(lvl ? "seg_high_ticks" : "seg_low_ticks", n, e.n);
      chk("seg_level", int'(lvl), int'(e.lvl));
    end
  endtask

  task automatic step();
    @(posedge clk21m);
    #1;
  endtask

  // Clock enable: irregular pattern averaging one tick per three clocks.
  initial begin
    forever begin
      @(posedge clk21m);
      #1;
      ce_3m58_p = ($urandom_range(2) == 0);
    end
  end

  // Output monitor: counts ticks per level while the player should be running.
  initial begin
    forever begin
      @(negedge clk21m);
      if (cas_motor && play_en && !eof && ce_3m58_p) begin
        if (cas_audio_out === mon_cur) begin
          mon_cnt++;
        end else begin
          if (mon_started) check_seg(mon_cur, mon_cnt);
          mon_started = 1;
          mon_cur = cas_audio_out;
          mon_cnt = 1;
        end
      end
      if (flush_req) begin
        if (mon_started && mon_cnt > 0) check_seg(mon_cur, mon_cnt);
        chk("seg_queue_drained", exp_q.size(), 0);
        mon_started = 0;
        mon_cur = 0;
        mon_cnt = 0;
        flush_req = 0;
      end
    end
  end

  // Memory model: checks address order, held request, and release after ack.
  initial begin
    mem_ack = 1'b0;
    mem_dout = '0;
    forever begin
      @(negedge clk21m);
      if (mem_rd === 1'b1) begin
        mm_a = int'(mem_addr);
        chk("addr_expected_avail", int'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) chk("addr_order", mm_a, addr_q.pop_front());
        mm_lat = (ack_lat == 0) ? int'($urandom_range(3, 1)) : ack_lat;
        for (int k = 1; k < mm_lat; k++) @(negedge clk21m);
        chk("addr_hold", int'(mem_addr), mm_a);
        chk("rd_hold", int'(mem_rd), 1);
        mem_dout = img[mm_a[5:0]];
        mem_ack = 1'b1;
        @(negedge clk21m);
        mem_ack = 1'b0;
        chk("rd_drop", int'(mem_rd), 0);
      end
    end
  end

  task automatic start_image(input int size, input int lat);
    play_en = 0;
    cas_motor = 1;
    step();
    rewind = 1;
    step();
    rewind = 0;
    cas_size = 27'(size);
    ack_lat = lat;
    build_expect(size);
    play_en = 1;
  endtask

  task automatic wait_high(input string tag);
    int i;
    i = 0;
    while (cas_audio_out !== 1'b1 && i < 2000) begin
      step();
      i++;
    end
    chk(tag, int'(cas_audio_out), 1);
  endtask

  task automatic finish_image(input string tag);
    int i;
    i = 0;
    while (eof !== 1'b1 && i < 30000) begin
      step();
      i++;
    end
    chk({tag, "_eof"}, int'(eof), 1);
    repeat (3) step();
    chk({tag, "_done_out"}, int'(cas_audio_out), 0);
    chk({tag, "_done_playing"}, int'(playing), 0);
    flush_req = 1;
    i = 0;
    while (flush_req && i < 10) begin
      step();
      i++;
    end
    chk({tag, "_flush"}, int'(flush_req), 0);
    chk({tag, "_addr_drained"}, addr_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    repeat (3) step();
    chk("rst_audio", int'(cas_audio_out), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_eof", int'(eof), 0);
    reset = 0;
    step();

    // Long header followed by a 0x00 frame.
    put_marker(0);
    img[8] = 8'h00;
    start_image(9, 1);
    finish_image("long_hdr");

    // Assorted non-marker bytes over two groups, random ack latency.
    img[0] = 8'hA5; img[1] = 8'h3C; img[2] = 8'hFF; img[3] = 8'h00;
    img[4] = 8'h5A; img[5] = 8'h81; img[6] = 8'h7E; img[7] = 8'hC3;
    img[8] = 8'h96;
    start_image(9, 0);
    wait_high("bytes_started");
    step();
    chk("bytes_playing", int'(playing), 1);
    finish_image("bytes");

    // Marker at offset 16: gap, short header, then one byte.
    for (int i = 0; i < 16; i++) img[i] = 8'((i * 37 + 5) & 255);
    put_marker(16);
    img[24] = 8'h42;
    start_image(25, 1);
    finish_image("short_hdr");

    // Motor off in the middle of a bit.
    img[0] = 8'h0F;
    img[1] = 8'h33;
    start_image(2, 2);
    wait_high("motor_started");
    repeat (4) step();
    cas_motor = 0;
    repeat (300) step();
    chk("motor_off_out", int'(cas_audio_out), 0);
    chk("motor_off_playing", int'(playing), 0);
    cas_motor = 1;
    finish_image("motor");

    // Three-byte image, then rewind from DONE.
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03;
    start_image(3, 1);
    finish_image("size3");
    play_en = 0;
    rewind = 1;
    step();
    rewind = 0;
    chk("rewind_eof", int'(eof), 0);
    chk("rewind_addr", int'(mem_addr), 0);

    // Slow memory: request held, output quiet until the group starts.
    img[0] = 8'h55;
    start_image(1, 40);
    repeat (30) step();
    chk("slow_rd_held", int'(mem_rd), 1);
    chk("slow_addr", int'(mem_addr), 0);
    chk("slow_out_quiet", int'(cas_audio_out), 0);
    finish_image("slow_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
